// File: rtl/alu_control_md.sv
// alu_control_md
// ALU control for the single-cycle RV core with an iterative M-extension
// sequencer. The decoder turns {funct7, ALU_Op, funct3} into the 4-bit ALU
// operation code. MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU are executed
// one radix-2 step per clock while the core is stalled.
//
// Parameters
//   XLEN      operand/result width (even, >= 8)
//   ENABLE_M  1 = sequencer present, 0 = M encodings reported illegal
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low
//   valid_i          instruction in decode is valid
//   funct7_i         instruction[31:25]
//   ALU_Op_i         000 R-type, 001 I-type, 010 LUI, others ADD
//   funct3_i         instruction[14:12]
//   rs1_data_i       operand A (dividend / multiplicand)
//   rs2_data_i       operand B (divisor / multiplier)
//   ALU_Operation_o  combinational ALU op code
//   illegal_o        unsupported encoding while valid_i
//   stall_o          hold PC/pipeline until the M result is ready
//   md_sel_o         writeback selects md_result_o
//   md_done_o        registered, md_result_o is valid this cycle
//   md_result_o      M-extension result, held until the next completion
module alu_control_md #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      ALU_Op_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [3:0]      ALU_Operation_o,
  output logic            illegal_o,
  output logic            stall_o,
  output logic            md_sel_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] md_result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_LUI  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier / dividend shifting into quotient
  logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;     // final result must be negated
  logic [XLEN-1:0] res_q, res_d;
  logic            done_q, done_d;

  logic [3:0] alu_op;
  logic       enc_illegal;
  logic       enc_md;
  logic       is_md;

  // Instruction decode. M encodings and illegal encodings fall back to
  // op 0000 so the ALU sees a harmless ADD.
  always_comb begin
    alu_op      = OP_ADD;
    enc_illegal = 1'b0;
    enc_md      = 1'b0;
    case (ALU_Op_i)
      3'b000: begin
        if (funct7_i == F7_MD) begin
          enc_md      = 1'b1;
          enc_illegal = (ENABLE_M == 1'b0);
        end else if (funct7_i == F7_BASE) begin
          case (funct3_i)
            3'b000:  alu_op = OP_ADD;
            3'b001:  alu_op = OP_SLL;
            3'b010:  alu_op = OP_SLT;
            3'b011:  alu_op = OP_SLTU;
            3'b100:  alu_op = OP_XOR;
            3'b101:  alu_op = OP_SRL;
            3'b110:  alu_op = OP_OR;
            default: alu_op = OP_AND;
          endcase
        end else if (funct7_i == F7_ALT) begin
          case (funct3_i)
            3'b000:  alu_op = OP_SUB;
            3'b101:  alu_op = OP_SRA;
            default: enc_illegal = 1'b1;
          endcase
        end else begin
          enc_illegal = 1'b1;
        end
      end
      3'b001: begin
        // funct7 only matters for the immediate shifts
        case (funct3_i)
          3'b000:  alu_op = OP_ADD;
          3'b001: begin
            if (funct7_i == F7_BASE) alu_op = OP_SLL;
            else enc_illegal = 1'b1;
          end
          3'b010:  alu_op = OP_SLT;
          3'b011:  alu_op = OP_SLTU;
          3'b100:  alu_op = OP_XOR;
          3'b101: begin
            if (funct7_i == F7_BASE) alu_op = OP_SRL;
            else if (funct7_i == F7_ALT) alu_op = OP_SRA;
            else enc_illegal = 1'b1;
          end
          3'b110:  alu_op = OP_OR;
          default: alu_op = OP_AND;
        endcase
      end
      3'b010:  alu_op = OP_LUI;
      default: alu_op = OP_ADD;
    endcase
    if (enc_illegal || enc_md) alu_op = OP_ADD;
  end

  assign is_md           = valid_i & enc_md & ENABLE_M;
  assign ALU_Operation_o = alu_op;
  assign illegal_o       = valid_i & enc_illegal;
  assign md_sel_o        = is_md;
  assign stall_o         = is_md & ~done_q;
  assign md_done_o       = done_q;
  assign md_result_o     = res_q;

  // Operand preparation at accept: signedness comes from funct3, operands
  // become magnitudes and the sign of the final result is remembered.
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            res_neg;
  logic            div_by_zero, div_ovf;

  always_comb begin
    if (funct3_i[2]) begin
      a_signed = ~funct3_i[0];
      b_signed = ~funct3_i[0];
    end else begin
      a_signed = (funct3_i[1:0] != 2'b11);
      b_signed = ~funct3_i[1];
    end
    a_neg = a_signed & rs1_data_i[XLEN-1];
    b_neg = b_signed & rs2_data_i[XLEN-1];
    a_mag = a_neg ? ('0 - rs1_data_i) : rs1_data_i;
    b_mag = b_neg ? ('0 - rs2_data_i) : rs2_data_i;
    // remainder takes the dividend's sign, everything else the product sign
    res_neg     = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_by_zero = (rs2_data_i == '0);
    div_ovf     = ~funct3_i[0] & (rs1_data_i == MOST_NEG) & (rs2_data_i == '1);
  end

  // One shift-add multiply step: add the multiplicand into the high half
  // when the current multiplier bit is set, then shift the pair right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, lo_q[XLEN-1:1]};
    mul_prod = neg_q ? ('0 - mul_next) : mul_next;
    mul_res  = (op_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // One restoring-division step. Bit XLEN of the trial difference is the
  // borrow: clear means the divisor fit and the quotient bit is 1.
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_fit;
  logic [XLEN-1:0] rem_next, quo_next;
  logic [XLEN-1:0] rem_fix, quo_fix;
  logic [XLEN-1:0] div_res;

  always_comb begin
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_fit   = ~div_diff[XLEN];
    rem_next  = div_fit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_next  = {lo_q[XLEN-2:0], div_fit};
    rem_fix   = neg_q ? ('0 - rem_next) : rem_next;
    quo_fix   = neg_q ? ('0 - quo_next) : quo_next;
    div_res   = op_q[1] ? rem_fix : quo_fix;
  end

  // Sequencer next state. Dropping valid_i mid-operation abandons the
  // instruction without touching the held result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_md) begin
          op_d  = funct3_i;
          neg_d = res_neg;
          cnt_d = '0;
          hi_d  = '0;
          if (!funct3_i[2]) begin
            opnd_d  = a_mag;
            lo_d    = b_mag;
            state_d = S_MUL;
          end else if (div_by_zero) begin
            res_d   = funct3_i[1] ? rs1_data_i : '1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            res_d   = funct3_i[1] ? '0 : rs1_data_i;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            opnd_d  = b_mag;
            lo_d    = a_mag;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (!valid_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          hi_d  = mul_next[2*XLEN-1:XLEN];
          lo_d  = mul_next[XLEN-1:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            cnt_d   = '0;
            res_d   = mul_res;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (!valid_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          hi_d  = rem_next;
          lo_d  = quo_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            cnt_d   = '0;
            res_d   = div_res;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
Parametrised next-generation ALU control for the single-cycle RV core.
- Decodes {funct7, ALU_Op, funct3} into the ALU operation code, adding SRA, SLT and SLTU, and correcting the ORI mapping.
- Adds an iterative M-extension sequencer (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that stalls the core until the result is ready.
- Sits between the control unit/register file and the ALU/writeback mux.

Parameters:
XLEN, 32, operand/result width (any even value >= 8)
ENABLE_M, 1, 1 = M-extension sequencer present; 0 = M encodings flagged illegal

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
valid_i  in  1  instruction in decode is valid
funct7_i  in  7  instruction[31:25]
ALU_Op_i  in  3  000 R-type, 001 I-type, 010 LUI, others treated as ADD
funct3_i  in  3  instruction[14:12]
rs1_data_i  in  XLEN  operand A (dividend/multiplicand)
rs2_data_i  in  XLEN  operand B (divisor/multiplier)
ALU_Operation_o  out  4  combinational ALU op code
illegal_o  out  1  combinational, unsupported encoding while valid_i
stall_o  out  1  combinational, hold PC/pipeline
md_sel_o  out  1  writeback selects md_result_o
md_done_o  out  1  registered, result valid this cycle
md_result_o  out  XLEN  M-extension result

Behaviour:
- Op codes: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRA 0110, SRL 0111, LUI 1001, SLT 1010, SLTU 1011.
- R-type (funct7 0000000/0100000): standard RV32I mapping. SUB and SRA require 0100000; any other funct7 raises illegal_o.
- I-type: funct7 is ignored except for SLLI/SRLI/SRAI (0000000/0000000/0100000).
- LUI ignores funct3.
- Illegal or M encodings drive ALU_Operation_o = 0000.
- is_md = valid_i & ALU_Op_i==000 & funct7_i==0000001 & ENABLE_M. md_sel_o = is_md.
- FSM states: IDLE, MUL, DIV, DONE.
  - Reset: state IDLE, counter 0, md_done_o 0, md_result_o 0.
  - IDLE: on is_md, operands are latched at that edge (accept, cycle 0).
    - funct3[2]=0 -> MUL.
    - funct3[2]=1 -> DIV. If divisor 0 or signed overflow, go directly to DONE.
  - MUL/DIV: one radix-2 step per cycle for XLEN cycles, then DONE.
  - DONE: md_done_o=1 for exactly one cycle, then IDLE.
- Latency: md_done_o high in cycle XLEN+1 after accept; cycle 1 for special-case divides.
- stall_o = is_md & ~md_done_o. It is low in the DONE cycle so the core retires that cycle.
- MUL datapath: operands are converted to magnitudes per signedness (MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned). A 2·XLEN unsigned shift-add product is formed and negated if signs differ. MUL returns the low half; the others return the high half.
- DIV datapath: restoring division on magnitudes.
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A) (signed ops only).
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (A = most-negative, B = -1): quotient = A; remainder 0.
- Flush: valid_i low while in MUL/DIV aborts to IDLE next edge. md_done_o is not asserted and md_result_o keeps its old value.
- md_result_o holds its last value until the next DONE.
- Reset asserted mid-operation: immediate return to reset values.
- Operand changes after accept have no effect on the result.

Test Plan:
- Decode sweep: R SRA (funct7 0100000, f3 101) -> 0110; ORI -> 0011; SLTU -> 1011; LUI any f3 -> 1001; R f7 0000010 -> illegal_o=1, op 0000.
- MUL 7 × 0xFFFFFFFD (XLEN=32) -> stall_o high cycles 0..32, md_done_o at cycle 33, result 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 -> 0x40000000.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM of same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- DIV 100/0 -> 0xFFFFFFFF at cycle 1. REM 100/0 -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1, REM -> 0.
- reset low at cycle 10 of MUL -> outputs 0, IDLE. valid_i low at cycle 5 of DIV -> no md_done_o, stall_o low, next accept works normally.
